bch_multi_decoder_mem: RTL

//  Multi-block BCH decode sequencer for PUF key recovery. Latches NUM_BLK raw PUF blocks, reads each block's
//  ECC parity (helper data) from synchronous byte memory, launches an external BCH decoder core per block, and

---
 rtl/bch_multi_decoder_mem_pkg.sv | 24 ++
 rtl/bch_multi_decoder_mem_parity.sv | 37 +++
 rtl/bch_multi_decoder_mem.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/bch_multi_decoder_mem_pkg.sv
// Shared FSM state encoding and sizing helpers for the multi-block BCH decode sequencer.
package bch_multi_decoder_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic int nbytes_f(input int bits, input int width);
        return (bits + width - 1) / width;
    endfunction

    // Never returns less than 1 so it is always usable as a vector width.
    function automatic int clog2_f(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/bch_multi_decoder_mem_parity.sv
// Byte counter and LSB-first assembly of ECC_BITS parity from NBYTES helper-memory reads.
module bch_parity_assembler
    import bch_multi_decoder_mem_pkg::*;
#(
    parameter int ECC_BITS = 10,
    parameter int MEM_DA_B = 8,
    localparam int NBYTES = nbytes_f(ECC_BITS, MEM_DA_B),
    localparam int CW = clog2_f(NBYTES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch,
    input  logic [MEM_DA_B-1:0] mem_data,
    output logic [CW-1:0]       byte_cnt,
    output logic [ECC_BITS-1:0] parity,
    output logic                last
);

    assign last = (byte_cnt == CW'(NBYTES));

    // Byte k arrives while byte_cnt == k+1; surplus bits of the last byte are never stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            parity   <= '0;
        end else if (fetch) begin
            byte_cnt <= last ? '0 : byte_cnt + 1'b1;
            for (int i = 0; i < ECC_BITS; i++) begin
                if (byte_cnt == CW'(i / MEM_DA_B + 1))
                    parity[i] <= mem_data[i % MEM_DA_B];
            end
        end else begin
            byte_cnt <= '0;
        end
    end

endmodule

// File: rtl/bch_multi_decoder_mem.sv
// Multi-block BCH decode sequencer: fetches helper parity, launches the decoder per block, collects results.
// Optional build macro BCH_MULTI_RETRY_EN: one re-fetch/re-launch of a block after its first decode failure.
module bch_multi_decoder_mem
    import bch_multi_decoder_mem_pkg::*;
#(
    parameter int DATA_BITS = 5,
    parameter int ECC_BITS  = 10,
    parameter int NUM_BLK   = 4,
    parameter int MEM_AD_B  = 5,
    parameter int MEM_DA_B  = 8,
    parameter int MEM_BASE  = 4
) (
    input  logic                           I_clk,
    input  logic                           I_rst,
    input  logic                           I_en,
    input  logic                           I_start,
    input  logic [NUM_BLK*DATA_BITS-1:0]   I_data,
    input  logic [MEM_DA_B-1:0]            I_mem_data,
    output logic [MEM_AD_B-1:0]            O_mem_addr,
    output logic                           O_dec_start,
    output logic [DATA_BITS+ECC_BITS-1:0]  O_dec_cw,
    input  logic                           I_dec_done,
    input  logic [DATA_BITS-1:0]           I_dec_data,
    input  logic                           I_dec_fail,
    output logic [NUM_BLK*DATA_BITS-1:0]   O_data,
    output logic [NUM_BLK-1:0]             O_fail,
    output logic                           O_busy,
    output logic                           O_ready
`ifdef BCH_MULTI_RETRY_EN
    ,
    output logic [NUM_BLK-1:0]             O_retry
`endif
);

    localparam int NBYTES = nbytes_f(ECC_BITS, MEM_DA_B);
    localparam int CW     = clog2_f(NBYTES + 1);
    localparam int BW     = clog2_f(NUM_BLK);

    state_t                         state, state_nx;
    logic [BW-1:0]                  blk;
    logic [NUM_BLK*DATA_BITS-1:0]   raw;
    logic [DATA_BITS-1:0]           raw_blk;
    logic [ECC_BITS-1:0]            parity;
    logic [CW-1:0]                  byte_cnt;
    logic                           fetch_last;
    logic                           fetching;
    logic                           accept;
    logic                           last_blk;
    logic                           retry_now;

    function automatic logic [MEM_AD_B-1:0] blk_addr(input logic [BW-1:0] b);
        return MEM_AD_B'(MEM_BASE + int'(b) * NBYTES);
    endfunction

    bch_parity_assembler #(
        .ECC_BITS (ECC_BITS),
        .MEM_DA_B (MEM_DA_B)
    ) u_asm (
        .clk      (I_clk),
        .rst      (I_rst),
        .fetch    (fetching),
        .mem_data (I_mem_data),
        .byte_cnt (byte_cnt),
        .parity   (parity),
        .last     (fetch_last)
    );

    assign accept   = I_en && I_start && (state == ST_IDLE || state == ST_DONE);
    assign last_blk = (blk == BW'(NUM_BLK - 1));
    assign raw_blk  = raw[int'(blk) * DATA_BITS +: DATA_BITS];
    assign O_dec_cw = {parity, raw_blk};

`ifdef BCH_MULTI_RETRY_EN
    assign retry_now = I_dec_fail && !O_retry[blk];
`else
    assign retry_now = 1'b0;
`endif

    always_ff @(posedge I_clk) begin
        if (I_rst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!I_en) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (I_start) state_nx = ST_FETCH;
                ST_FETCH:         if (fetch_last) state_nx = ST_LAUNCH;
                ST_LAUNCH:        state_nx = ST_WAIT;
                ST_WAIT: begin
                    if (I_dec_done)
                        state_nx = (last_blk && !retry_now) ? ST_DONE : ST_FETCH;
                end
                default:          state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        O_dec_start = 1'b0;
        O_busy      = 1'b0;
        O_ready     = 1'b0;
        fetching    = 1'b0;
        case (state)
            ST_FETCH: begin
                O_busy   = 1'b1;
                fetching = I_en;
            end
            ST_LAUNCH: begin
                O_busy      = 1'b1;
                O_dec_start = 1'b1;
            end
            ST_WAIT: O_busy  = 1'b1;
            ST_DONE: O_ready = 1'b1;
            default: ;
        endcase
    end

    // Address is registered so byte k is already on the bus in FETCH cycle k.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            blk        <= '0;
            raw        <= '0;
            O_data     <= '0;
            O_fail     <= '0;
            O_mem_addr <= '0;
`ifdef BCH_MULTI_RETRY_EN
            O_retry    <= '0;
`endif
        end else if (I_en) begin
            if (accept) begin
                raw        <= I_data;
                O_data     <= '0;
                O_fail     <= '0;
                blk        <= '0;
                O_mem_addr <= blk_addr('0);
`ifdef BCH_MULTI_RETRY_EN
                O_retry    <= '0;
`endif
            end else if (state == ST_FETCH && byte_cnt < CW'(NBYTES - 1)) begin
                O_mem_addr <= O_mem_addr + 1'b1;
            end else if (state == ST_WAIT && I_dec_done) begin
                if (retry_now) begin
`ifdef BCH_MULTI_RETRY_EN
                    O_retry[blk] <= 1'b1;
`endif
                    O_mem_addr <= blk_addr(blk);
                end else begin
                    if (I_dec_fail) begin
                        O_data[int'(blk) * DATA_BITS +: DATA_BITS] <= raw_blk;
                        O_fail[blk] <= 1'b1;
                    end else begin
                        O_data[int'(blk) * DATA_BITS +: DATA_BITS] <= I_dec_data;
                        O_fail[blk] <= 1'b0;
                    end
                    if (!last_blk) begin
                        blk        <= blk + 1'b1;
                        O_mem_addr <= blk_addr(blk + 1'b1);
                    end
                end
            end
        end
    end

endmodule
